// File: rtl/rr_arb_enc8.sv
// rr_arb_enc8 - eight-way round-robin arbiter with a binary-encoded grant.
//
// The winner is offered as a 3-bit index, which feeds a downstream 3-to-8
// decoder. An offer is held until the consumer accepts it. Each accepted
// offer (a handshake) advances the round-robin pointer to just past the
// winner and bumps a wrapping handshake counter.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous reset, active-high
//   req[7:0]     request lines, bit i = requester i asking for service
//   grant_ready  consumer accepts grant_idx this cycle
//   grant_idx    binary index of the current winner
//   grant_valid  grant_idx holds a valid offer
//   grant_count  completed handshakes, modulo 256
//
// Parameter
//   PRIO_INIT    pointer value after reset (0..7)
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no offer outstanding, arbitrate whenever req!=0
// OFFER | grant_idx is offered, held until grant_ready

module rr_arb_enc8 #(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       grant_ready,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic [7:0] grant_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_grant_idx;
  logic       r_grant_valid;
  logic [7:0] r_grant_count;

  logic       w_hs;
  logic [2:0] w_next_ptr;
  logic [2:0] w_arb_ptr;
  logic [2:0] w_cand;
  logic [2:0] w_win;
  logic       w_found;

  assign w_hs       = r_grant_valid & grant_ready;
  assign w_next_ptr = r_grant_idx + 3'd1;

  // A handshake arbitrates with the already-advanced pointer so that the
  // requester just served drops to lowest priority for the very next grant.
  assign w_arb_ptr = w_hs ? w_next_ptr : r_ptr;

  // Scan from the farthest candidate back to the pointer, so the candidate
  // closest to the pointer (pointer inclusive) is the last one to overwrite.
  always_comb begin
    w_found = 1'b0;
    w_win   = w_arb_ptr;
    w_cand  = w_arb_ptr;
    for (int k = 7; k >= 0; k--) begin
      w_cand = w_arb_ptr + 3'(k);
      if (req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= 3'd0;
      r_grant_count <= 8'd0;
      r_ptr         <= 3'(PRIO_INIT);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_idx   <= w_win;
            r_grant_valid <= 1'b1;
            r_state       <= OFFER;
          end
        end
        OFFER: begin
          // Without grant_ready the offer is frozen regardless of req.
          if (grant_ready) begin
            r_ptr         <= w_next_ptr;
            r_grant_count <= r_grant_count + 8'd1;
            if (w_found) begin
              r_grant_idx <= w_win;
            end else begin
              r_grant_valid <= 1'b0;
              r_state       <= IDLE;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign grant_count = r_grant_count;

endmodule

// File: doc/rr_arb_enc8.md
RR_ARB_ENC8 -- requirements
Module: rr_arb_enc8

Interface
REQ-001 The block SHALL have a single parameter: PRIO_INIT, default 0, giving the pointer value after reset (0..7).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 req  input  8  request lines; bit i set means requester i is asking for service.
REQ-005 grant_ready  input  1  the consumer accepts grant_idx this cycle.
REQ-006 grant_idx  output  3  binary index of the current winner, for the downstream 3-to-8 decoder.
REQ-007 grant_valid  output  1  grant_idx holds a valid offer.
REQ-008 grant_count  output  8  count of completed handshakes, wrapping modulo 256.

Function
REQ-009 The block SHALL hold an internal 3-bit round-robin pointer ptr.
REQ-010 Arbitration SHALL select the first set bit of req, searching from index ptr upward and wrapping from 7 to 0, with ptr inclusive.
REQ-011 The FSM SHALL have two states: IDLE (grant_valid=0) and OFFER (grant_valid=1).
REQ-012 In IDLE, with req!=0, the block SHALL register the winner into grant_idx and enter OFFER, so grant_valid rises exactly 1 cycle after req is sampled.
REQ-013 In IDLE, with req==0, the block SHALL stay in IDLE and leave grant_idx unchanged.
REQ-014 In OFFER, with grant_ready=0, grant_idx SHALL stay stable, even if req changes or drops to 0; an offer is never withdrawn.
REQ-015 A handshake (grant_valid & grant_ready) SHALL set ptr to (grant_idx+1) mod 8 and grant_count to grant_count+1, with 8'hFF wrapping to 8'h00.
REQ-016 In the handshake cycle, the block SHALL arbitrate on the current req using the advanced pointer:
- if a winner exists, load it into grant_idx and remain in OFFER, giving back-to-back grants at one per cycle;
- otherwise, go to IDLE, so grant_valid is 0 on the next cycle.
REQ-017 A requester that holds req after being granted SHALL have lowest priority on the next round, but SHALL win again if it is the only requester.
REQ-018 ptr SHALL change only on a handshake or on reset.
REQ-019 grant_ready asserted while grant_valid=0 SHALL have no effect.
REQ-020 grant_idx SHALL always be the index of a bit that was set in req at the cycle it was loaded.

Reset
REQ-021 When rst=1 at a clock edge, the block SHALL set state=IDLE, grant_valid=0, grant_idx=3'd0, grant_count=8'd0 and ptr=PRIO_INIT, whatever else happens that cycle.
REQ-022 Reset SHALL take priority over a simultaneous handshake, which SHALL be discarded (no count increment and no ptr update).
REQ-023 Arbitration SHALL resume on the first edge after rst falls, following REQ-012.

Verification
REQ-024 Reset: assert rst for 2 cycles with req=8'hFF and grant_ready=1 -> grant_valid=0, grant_idx=0 and grant_count=0 throughout; on release, grant_idx=0 one cycle later.
REQ-025 Single requester: req=8'h04, grant_ready=1 held -> grant_valid=1 and grant_idx=2 on every cycle from 1 cycle after release; grant_count increments by 1 per cycle.
REQ-026 Full load: req=8'hFF, grant_ready=1, ptr=0 -> grant_idx sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles; grant_count=9 after 9 handshakes.
REQ-027 Backpressure: req=8'h81 with grant_ready=0 -> grant_idx=0 held for 5 cycles; then req=8'h00 -> still grant_valid=1, grant_idx=0; then grant_ready=1 for 1 cycle -> grant_valid=0 next cycle, ptr=1.
REQ-028 Wrap: grant index 6, then req=8'h41 -> next grant_idx=0 (search 7,0); after that handshake, req=8'h41 -> grant_idx=6.
REQ-029 Mid-offer reset: grant_valid=1, grant_idx=5, grant_count=3; pulse rst with grant_ready=1 -> all outputs 0 next cycle; no increment recorded.
